hexdisplay_ctrl: RTL
====================

# hexdisplay_ctrl

Display-source controller for the four-digit seven-segment readout on the DE0 board top level. Selects one of four sources for the 16-bit value fed to the four segmentdisplay digit instances: live 6502 PC, periodically sampled PC, last PS/2 keyboard byte, or last UART byte. Generates the `latch` qualifier those instances consume. A debounced push-button cycles the source.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable clk25 cycles required to accept a button level (10 ms).
- `SAMPLE_CYCLES`, default 2500000: latch period in sampled-PC mode (100 ms); must be ≥ 2.

Ports:
- `clk25` in 1: system clock, 25 MHz.
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `btn_n` in 1: raw mode button, active-low, asynchronous to clk25.
- `pc_in` in 16: CPU PC monitor value.
- `kbd_data` in 8: keyboard byte, valid when `kbd_strobe` is high.
- `kbd_strobe` in 1: one-cycle byte-valid pulse.
- `uart_data` in 8: UART byte, valid when `uart_strobe` is high.
- `uart_strobe` in 1: one-cycle byte-valid pulse.
- `digits` out 16: value for the digit instances; [3:0] drives HEX0 … [15:12] drives HEX3.
- `latch` out 1: digit instances load `digits` on a clock edge where `latch` is 1.
- `mode` out 2: current source select.
- `mode_led` out 4: one-hot copy of `mode`.

## Operation
- Button path: 2-flop synchronizer, then debounce. Counter resets on any change of the synchronized level. The accepted level updates after `DEBOUNCE_CYCLES` consecutive equal samples. An accepted 1→0 transition is a press; a release does nothing.
- Each press advances `mode`: 0 PC_LIVE → 1 PC_SAMPLED → 2 KBD → 3 UART → 0 (wrap).
- Capture runs in every mode:
  - `kbd_strobe` loads `kbd_last` ← `kbd_data` and increments 8-bit `kbd_count` (wraps FF→00).
  - UART path uses `uart_last`/`uart_count` identically.
  - Both kbd and uart strobes in the same cycle: both are captured.
- Source value per mode:
  - PC_LIVE / PC_SAMPLED: `pc_in`.
  - KBD: {`kbd_count`, `kbd_last`}.
  - UART: {`uart_count`, `uart_last`}.
  - The value always reflects the post-capture state of the same edge.
- `latch` per mode:
  - PC_LIVE: 1 every cycle; `digits` tracks `pc_in` with 1-cycle delay.
  - PC_SAMPLED: one-cycle pulse when sample counter reaches `SAMPLE_CYCLES`-1. Counter then wraps to 0.
  - KBD / UART: one-cycle pulse in the cycle after a strobe of the selected source. Strobes of the other source are captured but do not pulse.
  - Any mode change: one-cycle pulse in the cycle after `mode` updates, with `digits` showing the new source.
- In pulsed modes, `digits` updates only in `latch` cycles and holds otherwise.
- Sample counter clears to 0 on every mode change and runs only in PC_SAMPLED.

## Timing
- All outputs are registered.
- Reset values: `digits` 16'h0000, `latch` 0, `mode` 2'b00, `mode_led` 4'b0001. Internal counters, captures and the accepted button level (1, released) are also reset.
- First edge after reset release: `latch`=1, `digits`=`pc_in` (mode 0).
- Strobe in cycle N (selected source): `digits`={count+1, data} and `latch`=1 in cycle N+1 only.
- Button press latency: 2 sync cycles + `DEBOUNCE_CYCLES` to the `mode` change. `latch` pulse 1 cycle later.
- Press edge and strobe in the same cycle: capture occurs, `mode` advances, and a single change pulse shows the new mode's current value.
- Glitches shorter than `DEBOUNCE_CYCLES` never change `mode`.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). No pulse is emitted until release.

## Test plan
Use `DEBOUNCE_CYCLES`=4 and `SAMPLE_CYCLES`=8 for all scenarios.
- Reset release, `pc_in`=16'hFF00 → first cycle `latch`=1, `digits`=FF00. Change to E000 → `digits`=E000 next cycle. `mode_led`=0001.
- Button low for 3 cycles then high → `mode` stays 0. Low for 10 cycles → `mode`=1 exactly 6 cycles after first low. Single-cycle `latch` after. Release → no further change.
- Mode 1, `pc_in` incrementing every cycle → `latch` pulses every 8 cycles. `digits` equals `pc_in` sampled at that edge and holds between pulses.
- Mode 2, `kbd_strobe` with 8'hC1 → next cycle `digits`=01C1, `latch`=1 for one cycle. `uart_strobe` with 8'h41 → no latch. Advance to mode 3 → `digits`=0141 with one latch pulse.
- 256 keyboard strobes in mode 2 → `kbd_count` wraps, `digits`[15:8]=00 after the 256th.
- Simultaneous `kbd_strobe` and `uart_strobe` in mode 3 → both counts increment, one latch showing the UART value. Assert `rst_n` low mid-count → all outputs return to reset values immediately.

Source files
------------

// File: rtl/hexdisplay_ctrl_if.sv
// hexdisplay_ctrl_if: data/strobe bundle between the board top level and the
// seven-segment source controller.
//   pc_in       CPU PC monitor value
//   kbd_data    keyboard byte, qualified by kbd_strobe (1-cycle pulse)
//   uart_data   UART byte, qualified by uart_strobe (1-cycle pulse)
//   digits      16-bit value for the four digit instances ([3:0] = HEX0)
//   latch       digit instances load digits on an edge where latch is 1
//   mode        current source select
//   mode_led    one-hot copy of mode
// slave = controller side, master = source/display side.
interface hexdisplay_ctrl_if;
  logic [15:0] pc_in;
  logic [7:0]  kbd_data;
  logic        kbd_strobe;
  logic [7:0]  uart_data;
  logic        uart_strobe;
  logic [15:0] digits;
  logic        latch;
  logic [1:0]  mode;
  logic [3:0]  mode_led;

  modport slave (
    input  pc_in, kbd_data, kbd_strobe, uart_data, uart_strobe,
    output digits, latch, mode, mode_led
  );

  modport master (
    output pc_in, kbd_data, kbd_strobe, uart_data, uart_strobe,
    input  digits, latch, mode, mode_led
  );
endinterface

// File: rtl/hexdisplay_ctrl.sv
// hexdisplay_ctrl: picks the value shown on the four-digit seven-segment
// readout (live PC, periodically sampled PC, last keyboard byte, last UART
// byte) and generates the latch qualifier for the digit instances. A
// debounced active-low push-button cycles the source.
// Ports:
//   clk25   25 MHz system clock
//   rst_n   asynchronous active-low reset
//   btn_n   raw mode button, active-low, asynchronous to clk25
//   bus     hexdisplay_ctrl_if.slave (sources in, digits/latch/mode out)
// All outputs are registered.
module hexdisplay_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SAMPLE_CYCLES   = 2500000
) (
  input  logic               clk25,
  input  logic               rst_n,
  input  logic               btn_n,
  hexdisplay_ctrl_if.slave   bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = $clog2(SAMPLE_CYCLES);

  typedef enum logic [1:0] {
    PC_LIVE    = 2'd0,
    PC_SAMPLED = 2'd1,
    KBD        = 2'd2,
    UART       = 2'd3
  } mode_e;

  // button path
  logic [1:0]    r_sync;
  logic          r_btn_acc;
  logic [DW-1:0] r_db_cnt;
  logic          w_db_diff;
  logic          w_db_done;
  logic          w_press;

  // mode FSM
  mode_e         r_mode;
  mode_e         w_mode_nxt;
  logic          r_chg;

  // captures
  logic [7:0]    r_kbd_last;
  logic [7:0]    r_kbd_cnt;
  logic [7:0]    r_uart_last;
  logic [7:0]    r_uart_cnt;
  logic          r_kbd_hit;
  logic          r_uart_hit;

  // sampler and outputs
  logic [SW-1:0] r_samp;
  logic          w_samp_end;
  logic [15:0]   w_src;
  logic          w_latch;
  logic [15:0]   r_digits;
  logic          r_latch;
  logic [3:0]    r_mode_led;

  // ---------------- button synchronizer + debounce ----------------
  // The counter only runs while the synchronized level differs from the
  // accepted one; a bounce back to the accepted level restarts it.
  assign w_db_diff = (r_sync[1] != r_btn_acc);
  assign w_db_done = w_db_diff && (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign w_press   = w_db_done && !r_sync[1];

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_btn_acc <= 1'b1;
      r_db_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], btn_n};
      if (!w_db_diff || w_db_done) r_db_cnt <= '0;
      else                         r_db_cnt <= r_db_cnt + 1'b1;
      if (w_db_done) r_btn_acc <= r_sync[1];
    end
  end

  // ---------------- mode FSM ----------------
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= PC_LIVE;
      r_mode_led <= 4'b0001;
      r_chg      <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_mode_led <= 4'b0001 << w_mode_nxt;
      r_chg      <= w_press;   // change pulse goes out one edge after mode moves
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_press) begin
      case (r_mode)
        PC_LIVE:    w_mode_nxt = PC_SAMPLED;
        PC_SAMPLED: w_mode_nxt = KBD;
        KBD:        w_mode_nxt = UART;
        UART:       w_mode_nxt = PC_LIVE;
        default:    w_mode_nxt = PC_LIVE;
      endcase
    end
  end

  // ---------------- byte captures (run in every mode) ----------------
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_kbd_last  <= 8'h00;
      r_kbd_cnt   <= 8'h00;
      r_uart_last <= 8'h00;
      r_uart_cnt  <= 8'h00;
      r_kbd_hit   <= 1'b0;
      r_uart_hit  <= 1'b0;
    end else begin
      r_kbd_hit  <= bus.kbd_strobe;
      r_uart_hit <= bus.uart_strobe;
      if (bus.kbd_strobe) begin
        r_kbd_last <= bus.kbd_data;
        r_kbd_cnt  <= r_kbd_cnt + 8'd1;
      end
      if (bus.uart_strobe) begin
        r_uart_last <= bus.uart_data;
        r_uart_cnt  <= r_uart_cnt + 8'd1;
      end
    end
  end

  // ---------------- sample counter ----------------
  // Cleared on the mode-change edge and on the change-pulse edge, so the
  // periodic pulses run SAMPLE_CYCLES apart starting from the change pulse.
  assign w_samp_end = (r_mode == PC_SAMPLED) && (r_samp == SW'(SAMPLE_CYCLES - 1));

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n)                                           r_samp <= '0;
    else if (w_press || r_chg || r_mode != PC_SAMPLED)    r_samp <= '0;
    else if (w_samp_end)                                  r_samp <= '0;
    else                                                  r_samp <= r_samp + 1'b1;
  end

  // ---------------- source select and latch ----------------
  // Sources come from the capture registers, so a strobe at edge N is
  // displayed (with its incremented count) at edge N+1.
  always_comb begin
    w_latch = r_chg;
    w_src   = bus.pc_in;
    case (r_mode)
      PC_LIVE:    w_latch = 1'b1;
      PC_SAMPLED: if (w_samp_end) w_latch = 1'b1;
      KBD: begin
        w_src = {r_kbd_cnt, r_kbd_last};
        if (r_kbd_hit) w_latch = 1'b1;
      end
      UART: begin
        w_src = {r_uart_cnt, r_uart_last};
        if (r_uart_hit) w_latch = 1'b1;
      end
      default: w_latch = r_chg;
    endcase
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= 16'h0000;
      r_latch  <= 1'b0;
    end else begin
      r_latch <= w_latch;
      if (w_latch) r_digits <= w_src;
    end
  end

  assign bus.digits   = r_digits;
  assign bus.latch    = r_latch;
  assign bus.mode     = r_mode;
  assign bus.mode_led = r_mode_led;

endmodule
